pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5, number of pipeline stages; index 0 = IF, STAGES-1 = WB.
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 Parameter STALL_LIMIT, default 1024, consecutive stalled cycles before deadlock flag.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 fetch_valid  input  1  IF has a new instruction for stage 0 this cycle.
REQ-007 stall_req  input  STAGES  stage i cannot advance this cycle.
REQ-008 flush_req  input  STAGES  stage k kills all younger stages (0..k-1).
REQ-009 stage_valid  output  STAGES  registered per-stage valid bit.
REQ-010 stage_stall  output  STAGES  combinational hold for stage i pipeline register.
REQ-011 fetch_ready  output  1  ~stage_stall[0]; IF may present next instruction.
REQ-012 retire  output  1  combinational pulse: valid instruction leaves last stage.
REQ-013 retire_cnt  output  CNT_W  retired-instruction count.
REQ-014 stall_cnt  output  CNT_W  cycles with stage_stall[0] high.
REQ-015 deadlock  output  1  sticky stall-timeout flag.
REQ-016 cnt_clr  input  1  synchronous clear of both counters and deadlock.

Function
REQ-017 stage_stall[i] SHALL equal OR of stall_req[j] for j>=i (older stall holds all younger stages).
REQ-018 kill[i] SHALL equal OR of flush_req[j] for j>i; flush_req[0] has no effect.
REQ-019 Stage i>0 next valid: stalled -> valid[i]&~kill[i]; else if stage_stall[i-1] -> 0 (bubble); else valid[i-1]&~kill[i-1].
REQ-020 Stage 0 next valid: stalled -> valid[0]&~kill[0]; else fetch_valid (redirected fetch is never killed).
REQ-021 Flush SHALL override stall: a killed stage becomes invalid next cycle even while held.
REQ-022 Requesting stage k of a flush SHALL itself advance/hold per normal rules.
REQ-023 retire SHALL equal valid[STAGES-1] & ~stage_stall[STAGES-1].
REQ-024 retire_cnt SHALL increment by 1 per retire cycle, saturating at all-ones.
REQ-025 stall_cnt SHALL increment per cycle with stage_stall[0]=1, saturating at all-ones.
REQ-026 Internal run counter SHALL count consecutive cycles with stage_stall[0]=1, reset to 0 on any cycle with it low.
REQ-027 deadlock SHALL set the cycle after run counter reaches STALL_LIMIT and stay set until rst or cnt_clr.
REQ-028 cnt_clr SHALL take priority over increment in the same cycle; valid bits unaffected.
REQ-029 Latency: instruction accepted with no stalls/flushes reaches stage_valid[STAGES-1] after STAGES cycles.

Reset
REQ-030 On rst: stage_valid=0, retire_cnt=0, stall_cnt=0, run counter=0, deadlock=0.
REQ-031 rst SHALL override all inputs; rst mid-operation discards all in-flight valids in one cycle.
REQ-032 Combinational outputs SHALL depend only on inputs and reset-cleared state (retire=0 after reset).

Structure
REQ-033 Shared package pipe_pkg SHALL hold stage-index constants (IF=0, ID=1, EX=2, MEM=3, WB=4) and default parameter values.
REQ-034 Sub-module sat_counter (width parameter, inc, clr, saturating) SHALL implement retire_cnt, stall_cnt and run counter.
REQ-035 Stall/kill prefix-OR SHALL be a generate loop over STAGES; no fixed-5 assumptions.

Verification (STAGES=5)
REQ-036 fetch_valid=1 continuous, no stalls -> stage_valid[4]=1 at cycle 5, retire each cycle after; retire_cnt=10 after 14 cycles.
REQ-037 One cycle stall_req[2]=1 with all valid -> stage_stall=5'b00111, stage_valid[3]=0 next cycle, stages 0..2 held.
REQ-038 flush_req[1]=1 with stall_req[3]=1 same cycle -> stage_valid[0] cleared next cycle despite stall, stage 1 held valid.
REQ-039 stall_req[0]=1 held 1030 cycles, STALL_LIMIT=1024 -> deadlock rises after 1024 stalled cycles, stays high; cnt_clr clears it and counters.
REQ-040 CNT_W=4, 20 retires -> retire_cnt saturates at 15.
REQ-041 rst asserted with all stages valid -> stage_valid=0 next cycle, counters 0, retire=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stage indices for the classic five-stage layout
// and the default parameter values used by pipe_ctrl.
package pipe_pkg;

  typedef enum logic [2:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stage_e;

  localparam int IF_STAGE  = 0;
  localparam int ID_STAGE  = 1;
  localparam int EX_STAGE  = 2;
  localparam int MEM_STAGE = 3;
  localparam int WB_STAGE  = 4;

  localparam int STAGES_DEF      = 5;
  localparam int CNT_W_DEF       = 32;
  localparam int STALL_LIMIT_DEF = 1024;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr has priority over inc, one-cycle update latency.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline valid/stall/flush control: registered stage valids, combinational holds and retire,
// older-stage stalls hold all younger stages, flushes kill younger stages even while held.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES      = STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_stall,
  output logic              fetch_ready,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              deadlock
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_LIMIT - 1);

  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [RUN_W-1:0]  run_cnt;
  logic              cnt_rst;
  logic              unused_flush0;

  // A flush from stage 0 has no younger stage to kill.
  assign unused_flush0 = flush_req[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign stage_stall[i] = |stall_req[STAGES-1:i];

    if (i == STAGES - 1) begin : g_last
      assign kill[i] = 1'b0;
    end else begin : g_kill
      assign kill[i] = |flush_req[STAGES-1:i+1];
    end

    if (i == 0) begin : g_fetch
      assign valid_d[i] = stage_stall[i] ? (valid_q[i] & ~kill[i]) : fetch_valid;
    end else begin : g_advance
      assign valid_d[i] = stage_stall[i] ? (valid_q[i] & ~kill[i])
                                         : (~stage_stall[i-1] & valid_q[i-1] & ~kill[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign stage_valid = valid_q;
  assign fetch_ready = ~stage_stall[0];
  assign retire      = valid_q[STAGES-1] & ~stage_stall[STAGES-1];
  assign cnt_rst     = rst | cnt_clr;

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .clr (cnt_rst),
    .inc (retire),
    .cnt (retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (cnt_rst),
    .inc (stage_stall[0]),
    .cnt (stall_cnt)
  );

  // Run length of the current unbroken stall; any free cycle restarts it.
  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk (clk),
    .clr (cnt_rst | ~stage_stall[0]),
    .inc (stage_stall[0]),
    .cnt (run_cnt)
  );

  // Trips on the edge where the run length reaches STALL_LIMIT.
  always_ff @(posedge clk) begin
    if (cnt_rst) begin
      deadlock <= 1'b0;
    end else if (stage_stall[0] && (run_cnt >= RUN_TRIP)) begin
      deadlock <= 1'b1;
    end
  end

endmodule
